// File: rtl/speaker_serializer_pkg.sv
// Shared frame/slot timing constants for the speaker serializer and tone generator.
package speaker_serializer_pkg;

   localparam int FRAME_LEN = 512;
   localparam int SLOT_LEN  = 16;
   localparam int SAMPLE_W  = 16;
   localparam int CNT_W     = 9;
   localparam int SLOT_BITS = $clog2(SLOT_LEN);

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   function automatic logic slot_last(input logic [CNT_W-1:0] c);
      return c[SLOT_BITS-1:0] == SLOT_BITS'(SLOT_LEN - 1);
   endfunction

endpackage

// File: rtl/speaker_serializer_shift16.sv
// Parallel-load, MSB-first shift register feeding the serial data line.
module spk_shift16
   import speaker_serializer_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                shift,
   input  logic [SAMPLE_W-1:0] din,
   output logic                msb
);

   logic [SAMPLE_W-1:0] sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= '0;
      end else if (load) begin
         sr <= din;
      end else if (shift) begin
         sr <= {sr[SAMPLE_W-2:0], 1'b0};
      end
   end

   assign msb = sr[SAMPLE_W-1];

endmodule

// File: rtl/speaker_serializer.sv
// Left-justified stereo DAC serializer: mclk/sck/lrck from a free-running frame counter.
// Optional mute input is enabled by defining SPK_MUTE_EN.
module speaker_serializer
   import speaker_serializer_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  sample_t audio_left,
   input  sample_t audio_right,
`ifdef SPK_MUTE_EN
   input  logic    mute,
`endif
   output logic    audio_mclk,
   output logic    audio_lrck,
   output logic    audio_sck,
   output logic    audio_sdin,
   output logic    sample_req
);

   logic [CNT_W-1:0]    cnt;
   sample_t             cap_left;
   sample_t             cap_right;
   sample_t             hold_right;
   logic                frame_end;
   logic                half_end;
   logic                sh_load;
   logic                sh_shift;
   logic [SAMPLE_W-1:0] sh_din;

   always_comb begin
      cap_left  = audio_left;
      cap_right = audio_right;
`ifdef SPK_MUTE_EN
      if (mute) begin
         cap_left  = '0;
         cap_right = '0;
      end
`endif
   end

   assign frame_end = (cnt == CNT_W'(FRAME_LEN - 1));
   assign half_end  = (cnt == CNT_W'(FRAME_LEN / 2 - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         sample_req <= 1'b0;
         hold_right <= '0;
      end else begin
         cnt        <= cnt + CNT_W'(1);
         sample_req <= frame_end;
         if (frame_end) begin
            hold_right <= cap_right;
         end
      end
   end

   // The shifter itself is the left holding register: it is loaded straight from
   // the capture mux so the left MSB is on sdin in the first cycle of the frame.
   assign sh_load  = frame_end | half_end;
   assign sh_shift = slot_last(cnt) & ~sh_load;
   assign sh_din   = frame_end ? cap_left : hold_right;

   spk_shift16 u_shift (
      .clk   (clk),
      .rst   (rst),
      .load  (sh_load),
      .shift (sh_shift),
      .din   (sh_din),
      .msb   (audio_sdin)
   );

   assign audio_mclk = cnt[1];
   assign audio_sck  = cnt[3];
   assign audio_lrck = cnt[CNT_W-1];

endmodule

// File: tb/tb_speaker_serializer.sv
// Self-checking bench for speaker_serializer: frame-level reference model plus vector table.
module tb_speaker_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] audio_left = '0;
   logic [15:0] audio_right = '0;
`ifdef SPK_MUTE_EN
   logic        mute = 1'b0;
`endif
   logic        audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_req;

   speaker_serializer dut (
      .clk         (clk),
      .rst         (rst),
      .audio_left  (audio_left),
      .audio_right (audio_right),
`ifdef SPK_MUTE_EN
      .mute        (mute),
`endif
      .audio_mclk  (audio_mclk),
      .audio_lrck  (audio_lrck),
      .audio_sck   (audio_sck),
      .audio_sdin  (audio_sdin),
      .sample_req  (sample_req)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // reference model: position within the frame and the words being sent
   int          p = 0;
   logic [15:0] m_l = '0;
   logic [15:0] m_r = '0;
   logic        m_req = 1'b0;

   // clock period tracking
   bit   track = 0;
   int   rel_cyc = 0;
   int   first_req = -1;
   int   last_m = -1, last_s = -1, last_f = -1;
   int   rise_m = 0, rise_s = 0, rise_f = 0, bad_int = 0;
   logic prev_m = 0, prev_s = 0, prev_f = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic step();
      logic [4:0] exp_v, got_v;
      logic       e_sdin;
      logic       muted;
      @(posedge clk);
      muted = 1'b0;
`ifdef SPK_MUTE_EN
      muted = mute;
`endif
      if (rst) begin
         p = 0; m_l = '0; m_r = '0; m_req = 1'b0;
      end else begin
         m_req = (p == 511);
         if (p == 511) begin
            m_l = muted ? 16'h0 : audio_left;
            m_r = muted ? 16'h0 : audio_right;
         end
         p = (p + 1) % 512;
      end
      cyc++;
      #1;
      e_sdin = (p < 256) ? m_l[15 - p / 16] : m_r[15 - (p - 256) / 16];
      exp_v = {((p / 2) % 2) == 1, ((p / 8) % 2) == 1, p >= 256, e_sdin, m_req};
      got_v = {audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req};
      total++;
      if (got_v !== exp_v) begin
         bad++;
         $display("FAIL model cyc=%0d {mclk,sck,lrck,sdin,req} got=%b exp=%b", cyc, got_v, exp_v);
      end
      if (track) begin
         if (sample_req && first_req < 0) first_req = cyc - rel_cyc;
         if (audio_mclk && !prev_m) begin
            if (last_m >= 0 && cyc - last_m != 4) bad_int++;
            last_m = cyc; rise_m++;
         end
         if (audio_sck && !prev_s) begin
            if (last_s >= 0 && cyc - last_s != 16) bad_int++;
            last_s = cyc; rise_s++;
         end
         if (audio_lrck && !prev_f) begin
            if (last_f >= 0 && cyc - last_f != 512) bad_int++;
            last_f = cyc; rise_f++;
         end
      end
      prev_m = audio_mclk; prev_s = audio_sck; prev_f = audio_lrck;
   endtask

   task automatic run_to_phase(input int target);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (p != target && n < 1100);
      if (p != target) begin
         total++; bad++;
         $display("FAIL run_to_phase got=%0d exp=%0d", p, target);
      end
   endtask

   // Sends one frame starting at phase 0, reading sdin at every sck rising edge.
   task automatic collect(input string name, input int chg_phase,
                          input logic [15:0] cl, input logic [15:0] cr,
                          input logic [15:0] el, input logic [15:0] er);
      logic [15:0] gl, gr;
      int slot;
      gl = '0; gr = '0;
      chk({name, "_start"}, p, 0);
      for (int i = 0; i < 512; i++) begin
         step();
         if (p % 16 == 8) begin
            slot = p / 16;
            if (slot < 16) gl[15 - slot] = audio_sdin;
            else           gr[31 - slot] = audio_sdin;
         end
         if (p == chg_phase) begin
            audio_left  = cl;
            audio_right = cr;
         end
      end
      chk({name, "_L"}, gl, el);
      chk({name, "_R"}, gr, er);
   endtask

   typedef struct {
      string       name;
      bit          set_in;
      bit          wait_f;
      logic [15:0] in_l, in_r;
      int          chg_phase;
      logic [15:0] chg_l, chg_r;
      logic [15:0] exp_l, exp_r;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{"frame0_zero", 1'b1, 1'b0, 16'hA5F0, 16'h0F0F, -1, 16'h0, 16'h0, 16'h0000, 16'h0000};
      vecs[1] = '{"a5f0_0f0f",   1'b0, 1'b0, 16'h0,    16'h0,    -1, 16'h0, 16'h0, 16'hA5F0, 16'h0F0F};
      vecs[2] = '{"hold_mid",    1'b1, 1'b1, 16'h8000, 16'h1111, 100, 16'h7FFF, 16'h2222, 16'h8000, 16'h1111};
      vecs[3] = '{"next_frame",  1'b0, 1'b0, 16'h0,    16'h0,    -1, 16'h0, 16'h0, 16'h7FFF, 16'h2222};
      vecs[4] = '{"lsb_msb",     1'b1, 1'b1, 16'h0001, 16'hFFFE, -1, 16'h0, 16'h0, 16'h0001, 16'hFFFE};

      // reset state
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("reset_outs", {audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req}, 5'b0);
      end
      rst = 1'b0;
      rel_cyc = cyc;
      track = 1;

      for (int i = 0; i < 5; i++) begin
         if (vecs[i].set_in) begin
            audio_left  = vecs[i].in_l;
            audio_right = vecs[i].in_r;
         end
         if (vecs[i].wait_f) run_to_phase(0);
         collect(vecs[i].name, vecs[i].chg_phase, vecs[i].chg_l, vecs[i].chg_r,
                 vecs[i].exp_l, vecs[i].exp_r);
         if (i == 1) begin
            track = 0;
            chk("first_req_cyc", first_req, 512);
            chk("mclk_rises", rise_m, 256);
            chk("sck_rises", rise_s, 64);
            chk("lrck_rises", rise_f, 2);
            chk("bad_periods", bad_int, 0);
         end
      end

      // inputs change exactly in the capture cycle
      audio_left = 16'h0; audio_right = 16'h0;
      run_to_phase(511);
      audio_left = 16'h1234; audio_right = 16'hABCD;
      step();
      collect("edge_cap", -1, 16'h0, 16'h0, 16'h1234, 16'hABCD);

      // mid-frame reset aborts the frame
      audio_left = 16'hFFFF; audio_right = 16'hFFFF;
      run_to_phase(300);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("midrst_outs", {audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req}, 5'b0);
      end
      rst = 1'b0;
      collect("post_rst_zero", -1, 16'h0, 16'h0, 16'h0000, 16'h0000);
      chk("req_after_rst", sample_req, 1'b1);
      collect("cap_after_rst", -1, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF);

`ifdef SPK_MUTE_EN
      // mute raised mid-frame only affects the next capture
      collect("mute_pre", -1, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF);
      for (int i = 0; i < 512; i++) begin
         step();
         if (p == 100) mute = 1'b1;
      end
      chk("mute_req", sample_req, 1'b1);
      collect("mute_zero", -1, 16'h0, 16'h0, 16'h0000, 16'h0000);
      mute = 1'b0;
`endif

      // randomized inputs, occasional reset, checked cycle by cycle against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) audio_left  = 16'($urandom);
         if ($urandom_range(0, 7) == 0) audio_right = 16'($urandom);
`ifdef SPK_MUTE_EN
         if ($urandom_range(0, 255) == 0) mute = ~mute;
`endif
         rst = (i >= 1700 && i < 1702);
         step();
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
